// File: rtl/arm_pipelined_execute_control_if.sv
// Decode-to-Execute control bundle: decoder/hazard-side inputs and the
// Execute-stage control, address and flag outputs of the ID/EX stage.
interface arm_pipelined_execute_control_if #(
  parameter int FlagsWidth = 4
);
  logic                  i_Flush_Execute;
  logic [3:0]            i_Cond_Decode;
  logic                  i_PCS_Decode;
  logic                  i_Reg_Write_Decode;
  logic                  i_Mem_Write_Decode;
  logic                  i_Mem_To_Reg_Decode;
  logic                  i_Branch_Decode;
  logic                  i_ALU_Src_Decode;
  logic [1:0]            i_ALU_Control_Decode;
  logic [1:0]            i_Flag_Write_Decode;
  logic [3:0]            i_WA3_Decode;
  logic [3:0]            i_RA1_Decode;
  logic [3:0]            i_RA2_Decode;
  logic [FlagsWidth-1:0] i_ALU_Flags;

  logic                  o_Valid_Execute;
  logic                  o_Cond_Ex;
  logic                  o_PC_Src_Execute;
  logic                  o_Reg_Write_Execute;
  logic                  o_Mem_Write_Execute;
  logic                  o_Branch_Taken_Execute;
  logic                  o_Mem_To_Reg_Execute;
  logic                  o_ALU_Src_Execute;
  logic [1:0]            o_ALU_Control_Execute;
  logic [3:0]            o_WA3_Execute;
  logic [3:0]            o_RA1_Execute;
  logic [3:0]            o_RA2_Execute;
  logic [FlagsWidth-1:0] o_Flags;

  modport master (
    output i_Flush_Execute, i_Cond_Decode, i_PCS_Decode, i_Reg_Write_Decode,
           i_Mem_Write_Decode, i_Mem_To_Reg_Decode, i_Branch_Decode,
           i_ALU_Src_Decode, i_ALU_Control_Decode, i_Flag_Write_Decode,
           i_WA3_Decode, i_RA1_Decode, i_RA2_Decode, i_ALU_Flags,
    input  o_Valid_Execute, o_Cond_Ex, o_PC_Src_Execute, o_Reg_Write_Execute,
           o_Mem_Write_Execute, o_Branch_Taken_Execute, o_Mem_To_Reg_Execute,
           o_ALU_Src_Execute, o_ALU_Control_Execute, o_WA3_Execute,
           o_RA1_Execute, o_RA2_Execute, o_Flags
  );

  modport slave (
    input  i_Flush_Execute, i_Cond_Decode, i_PCS_Decode, i_Reg_Write_Decode,
           i_Mem_Write_Decode, i_Mem_To_Reg_Decode, i_Branch_Decode,
           i_ALU_Src_Decode, i_ALU_Control_Decode, i_Flag_Write_Decode,
           i_WA3_Decode, i_RA1_Decode, i_RA2_Decode, i_ALU_Flags,
    output o_Valid_Execute, o_Cond_Ex, o_PC_Src_Execute, o_Reg_Write_Execute,
           o_Mem_Write_Execute, o_Branch_Taken_Execute, o_Mem_To_Reg_Execute,
           o_ALU_Src_Execute, o_ALU_Control_Execute, o_WA3_Execute,
           o_RA1_Execute, o_RA2_Execute, o_Flags
  );
endinterface

// File: rtl/arm_pipelined_execute_control.sv
// ID/EX pipeline register for control and register-address fields, with the
// NZCV flags register and ARM condition evaluation gating Execute enables.
module arm_pipelined_execute_control #(
  parameter int FlagsWidth = 4
) (
  input logic                             i_CLK,
  input logic                             i_RESET,
  arm_pipelined_execute_control_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic       pcs;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] flag_write;
    logic [3:0] wa3;
    logic [3:0] ra1;
    logic [3:0] ra2;
  } idex_t;

  localparam idex_t BUBBLE = '{
    valid: 1'b0, cond: 4'h0, pcs: 1'b0, reg_write: 1'b0, mem_write: 1'b0,
    mem_to_reg: 1'b0, branch: 1'b0, alu_src: 1'b0, alu_control: 2'b00,
    flag_write: 2'b00, wa3: 4'h0, ra1: 4'h0, ra2: 4'h0
  };

  idex_t                 idex_q;
  idex_t                 idex_d;
  logic [FlagsWidth-1:0] flags_q;
  logic [FlagsWidth-1:0] flags_d;
  logic                  cond_ex_s;

  // nzcv is ordered N=3, Z=2, C=1, V=0
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      4'hF:    cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Condition is judged against flags before this instruction's own update
  always_comb begin
    cond_ex_s = idex_q.valid & cond_pass(idex_q.cond, flags_q[3:0]);
  end

  // Next ID/EX contents: bubble on flush, otherwise the Decode word
  always_comb begin
    idex_d = BUBBLE;
    if (bus.i_Flush_Execute) begin
      idex_d = BUBBLE;
    end else begin
      idex_d.valid       = 1'b1;
      idex_d.cond        = bus.i_Cond_Decode;
      idex_d.pcs         = bus.i_PCS_Decode;
      idex_d.reg_write   = bus.i_Reg_Write_Decode;
      idex_d.mem_write   = bus.i_Mem_Write_Decode;
      idex_d.mem_to_reg  = bus.i_Mem_To_Reg_Decode;
      idex_d.branch      = bus.i_Branch_Decode;
      idex_d.alu_src     = bus.i_ALU_Src_Decode;
      idex_d.alu_control = bus.i_ALU_Control_Decode;
      idex_d.flag_write  = bus.i_Flag_Write_Decode;
      idex_d.wa3         = bus.i_WA3_Decode;
      idex_d.ra1         = bus.i_RA1_Decode;
      idex_d.ra2         = bus.i_RA2_Decode;
    end
  end

  // Next flags: NZ and CV halves update independently, only when the condition passes
  always_comb begin
    flags_d = flags_q;
    if (cond_ex_s && idex_q.flag_write[1]) begin
      flags_d[3:2] = bus.i_ALU_Flags[3:2];
    end else begin
      flags_d[3:2] = flags_q[3:2];
    end
    if (cond_ex_s && idex_q.flag_write[0]) begin
      flags_d[1:0] = bus.i_ALU_Flags[1:0];
    end else begin
      flags_d[1:0] = flags_q[1:0];
    end
  end

  // State update; reset wins over flush and flag writes
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      idex_q  <= BUBBLE;
      flags_q <= {FlagsWidth{1'b0}};
    end else begin
      idex_q  <= idex_d;
      flags_q <= flags_d;
    end
  end

  // Execute-stage outputs from registered state
  always_comb begin
    bus.o_Valid_Execute        = idex_q.valid;
    bus.o_Cond_Ex              = cond_ex_s;
    bus.o_PC_Src_Execute       = idex_q.pcs & cond_ex_s;
    bus.o_Reg_Write_Execute    = idex_q.reg_write & cond_ex_s;
    bus.o_Mem_Write_Execute    = idex_q.mem_write & cond_ex_s;
    bus.o_Branch_Taken_Execute = idex_q.branch & cond_ex_s;
    bus.o_Mem_To_Reg_Execute   = idex_q.mem_to_reg;
    bus.o_ALU_Src_Execute      = idex_q.alu_src;
    bus.o_ALU_Control_Execute  = idex_q.alu_control;
    bus.o_WA3_Execute          = idex_q.wa3;
    bus.o_RA1_Execute          = idex_q.ra1;
    bus.o_RA2_Execute          = idex_q.ra2;
    bus.o_Flags                = flags_q;
  end

endmodule

// File: doc/arm_pipelined_execute_control.md
# arm_pipelined_execute_control

Decode→Execute pipeline register for control and register-address fields, plus the NZCV flags register and ARM condition-check logic. Sits directly downstream of the fetch/decode datapath and the control decoder. It captures each decoded instruction's control word, evaluates its condition field against the architectural flags, and emits the gated write/branch enables consumed by the Execute, Memory and PC-select logic. It also exports the Execute-stage register addresses used by the hazard unit for forwarding and flush decisions.

## Interface
- `FlagsWidth`, 4, NZCV width; only the value 4 is supported.
- `i_CLK` in 1: clock; all state updates on the rising edge.
- `i_RESET` in 1: synchronous, active-high reset.
- `i_Flush_Execute` in 1: load a bubble instead of the Decode inputs; from the hazard unit.
- `i_Cond_Decode` in 4: instruction bits [31:28].
- `i_PCS_Decode`, `i_Reg_Write_Decode`, `i_Mem_Write_Decode`, `i_Mem_To_Reg_Decode`, `i_Branch_Decode`, `i_ALU_Src_Decode` in 1 each: decoder controls.
- `i_ALU_Control_Decode` in 2: ALU operation select.
- `i_Flag_Write_Decode` in 2: bit1 enables NZ update, bit0 enables CV update.
- `i_WA3_Decode`, `i_RA1_Decode`, `i_RA2_Decode` in 4 each: destination register and the two source registers after the A1/A2 muxes.
- `i_ALU_Flags` in 4: NZCV produced by the ALU for the instruction currently in Execute.
- `o_Valid_Execute` out 1: a non-bubble instruction occupies Execute.
- `o_Cond_Ex` out 1: condition passed.
- `o_PC_Src_Execute`, `o_Reg_Write_Execute`, `o_Mem_Write_Execute`, `o_Branch_Taken_Execute` out 1 each: condition-gated enables.
- `o_Mem_To_Reg_Execute`, `o_ALU_Src_Execute` out 1 each; `o_ALU_Control_Execute` out 2: registered, not gated.
- `o_WA3_Execute`, `o_RA1_Execute`, `o_RA2_Execute` out 4 each: registered addresses.
- `o_Flags` out 4: architectural NZCV register (N=bit3 … V=bit0).

## Operation
- **Pipeline register (ID/EX).**
  - Priority: `i_RESET` > `i_Flush_Execute` > load.
  - Reset or flush loads a bubble: all control bits 0, Cond=0000, ALU_Control=00, addresses 0, valid=0.
  - Otherwise it loads all Decode inputs and sets valid=1.
  - There is no enable; the register loads every cycle.
- **Condition check.** Combinational on the registered Cond and the `o_Flags` register. `o_Cond_Ex` = valid AND pass(Cond):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 0 (never executes)
- **Gated outputs.** PC_Src, Reg_Write, Mem_Write and Branch_Taken each equal the registered bit AND `o_Cond_Ex`.
- **Flags register.**
  - Reset value 0000.
  - At each edge, if `o_Cond_Ex`:
    - Flag_Write[1] loads N,Z from `i_ALU_Flags[3:2]`.
    - Flag_Write[0] loads C,V from `i_ALU_Flags[1:0]`.
  - Bits whose enable is 0 hold.
  - A failed condition or a bubble never updates flags.
- **Flag ordering.** The condition is evaluated against the flags *before* the current instruction's own update. A flag-setting instruction affects the condition of the very next instruction.

## Timing
- Latency is 1 cycle: Decode inputs present before edge N appear on the registered outputs after edge N.
- Gated outputs and `o_Cond_Ex` are valid in the same cycle, combinationally from registered state; there are no additional stages.
- Flags are written at the edge that ends the instruction's Execute cycle and are visible to the next Execute cycle.
- If `i_Flush_Execute` and a flag update coincide, the flag update of the instruction leaving Execute still occurs, and the incoming instruction is replaced by a bubble.
- If `i_RESET` is asserted mid-operation, the bubble and flags=0000 take effect at the next edge, overriding flush and flag writes. During reset all gated outputs are 0 after that edge.
- After reset release, the first Decode word is captured at the first edge with `i_RESET`=0.

## Test plan
- **Reset.** Hold reset 2 cycles with random inputs → all outputs 0, `o_Flags`=0000, `o_Valid_Execute`=0.
- **Flag set then conditional use.**
  - Load a CMP-like word: Cond=E, Flag_Write=11, ALU flags=0100.
  - Next word: Cond=0 (EQ), Reg_Write=1.
  - Required: `o_Flags`=0100 and `o_Reg_Write_Execute`=1.
  - Repeat with Cond=1 (NE) → `o_Reg_Write_Execute`=0.
- **Failed condition.** Flags=0000; load Cond=0, Flag_Write=11, ALU flags=1111 → `o_Cond_Ex`=0 and `o_Flags` stays 0000 after the edge.
- **Partial flag write.** Flags=1010; load Cond=E, Flag_Write=01, ALU flags=0101 → `o_Flags`=1001.
- **Flush.** Assert `i_Flush_Execute` while Decode presents Branch=1, PCS=1, Cond=E → next cycle Branch_Taken=0, PC_Src=0, Valid=0. Flags update from the prior instruction still applies.
- **Condition sweep.** For all 16 Cond values × 16 flag patterns, compare `o_Cond_Ex` against the table; Cond=F is always 0.
